// File: rtl/ssp_tx_framer.sv
// Byte FIFO plus MSB-first SSP serialiser (ssp_clk / ssp_frame / ssp_din) clocked from ck_1356meg.
// Optional build macro SSP_TEST_PATTERN_EN replaces the FIFO source with a repeating DE AD BE EF pattern when test_mode=1.
module ssp_tx_framer #(
  parameter int FIFO_DEPTH = 4,
  parameter int CLK_DIV    = 4
) (
  input  logic                          ck_1356meg,
  input  logic                          nrst,
  input  logic [7:0]                    wr_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic                          enable,
  input  logic                          test_mode,
  output logic                          ssp_clk,
  output logic                          ssp_frame,
  output logic                          ssp_din,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [2:0]       bit_cnt;
  logic [6:0]       shreg;
  logic [DIV_W-1:0] div_cnt;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level;

  logic       push;
  logic       pop;
  logic       clk_run;
  logic       tick;
  logic       fall_tick;
  logic       at_boundary;
  logic       load;
  logic       src_avail;
  logic       src_fifo;
  logic [7:0] src_byte;

  // ---------------------------------------------------------------------------
  // Byte FIFO
  // ---------------------------------------------------------------------------
  assign wr_ready   = (level < LVL_FULL);
  assign push       = wr_valid & wr_ready;
  assign fifo_level = level;

  // NOTE: the storage array has no reset; the pointers and level alone define
  // which entries are valid, so clearing the data would only cost area.
  always_ff @(posedge ck_1356meg) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // NOTE: every sequential assignment is non-blocking so all registers sample
  // the pre-edge values and simulation order between blocks cannot matter.
  always_ff @(posedge ck_1356meg or negedge nrst) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // ssp_clk divider, gated off while idle and disabled
  // ---------------------------------------------------------------------------
  assign clk_run   = (state == SHIFT) | enable;
  assign tick      = clk_run & (div_cnt == DIV_LAST);
  assign fall_tick = tick & ssp_clk;

  always_ff @(posedge ck_1356meg or negedge nrst) begin
    if (!nrst) begin
      div_cnt <= '0;
      ssp_clk <= 1'b0;
    end else if (!clk_run) begin
      div_cnt <= '0;
      ssp_clk <= 1'b0;
    end else if (tick) begin
      div_cnt <= '0;
      ssp_clk <= ~ssp_clk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Byte source selection
  // ---------------------------------------------------------------------------
`ifdef SSP_TEST_PATTERN_EN
  logic [1:0] pat_idx;
  logic [7:0] pat_byte;

  always_comb begin
    unique case (pat_idx)
      2'd0:    pat_byte = 8'hDE;
      2'd1:    pat_byte = 8'hAD;
      2'd2:    pat_byte = 8'hBE;
      default: pat_byte = 8'hEF;
    endcase
  end

  // Index restarts whenever a boundary sees test_mode low, so a fresh
  // pattern run always begins with DE.
  always_ff @(posedge ck_1356meg or negedge nrst) begin
    if (!nrst) begin
      pat_idx <= '0;
    end else if (fall_tick && at_boundary) begin
      if (!test_mode) pat_idx <= '0;
      else if (load)  pat_idx <= pat_idx + 1'b1;
    end
  end
`else
  // test_mode has no function in this build.
  logic unused_test_mode;
  assign unused_test_mode = test_mode;
`endif

  // NOTE: every output of this block gets a default first, so no path through
  // the conditional overrides can leave one unassigned and infer a latch.
  always_comb begin
    src_avail = (level != '0);
    src_fifo  = 1'b1;
    src_byte  = mem[rd_ptr];
`ifdef SSP_TEST_PATTERN_EN
    if (test_mode) begin
      src_avail = 1'b1;
      src_fifo  = 1'b0;
      src_byte  = pat_byte;
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Serialiser state machine, advanced only on falling ssp_clk ticks
  // ---------------------------------------------------------------------------
  assign at_boundary = (state == IDLE) | (bit_cnt == 3'd7);
  assign load        = fall_tick & at_boundary & enable & src_avail;
  assign pop         = load & src_fifo;
  assign busy        = (state == SHIFT);

  always_ff @(posedge ck_1356meg or negedge nrst) begin
    if (!nrst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      ssp_din   <= 1'b0;
      ssp_frame <= 1'b0;
    end else if (fall_tick) begin
      if (!at_boundary) begin
        ssp_din   <= shreg[6];
        shreg     <= {shreg[5:0], 1'b0};
        bit_cnt   <= bit_cnt + 3'd1;
        ssp_frame <= 1'b0;
      end else if (load) begin
        // Bit 7 goes straight to the pin; the remaining seven wait in shreg.
        ssp_din   <= src_byte[7];
        shreg     <= src_byte[6:0];
        ssp_frame <= 1'b1;
        bit_cnt   <= '0;
        state     <= SHIFT;
      end else begin
        ssp_din   <= 1'b0;
        ssp_frame <= 1'b0;
        bit_cnt   <= '0;
        state     <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_ssp_tx_framer.sv
// Self-checking bench for ssp_tx_framer: directed stimulus plus a per-cycle
// byte-stream model (expected bytes, bit timing, FIFO occupancy).
module tb_ssp_tx_framer;

  localparam int FIFO_DEPTH = 4;
  localparam int CLK_DIV    = 2;
  localparam int BIT_CYC    = 2 * CLK_DIV;
  localparam int WIN        = 8 * BIT_CYC;

  logic       ck_1356meg = 1'b0;
  logic       nrst       = 1'b0;
  logic [7:0] wr_data    = 8'h00;
  logic       wr_valid   = 1'b0;
  logic       enable     = 1'b0;
  logic       test_mode  = 1'b0;
  logic       wr_ready;
  logic       ssp_clk;
  logic       ssp_frame;
  logic       ssp_din;
  logic [2:0] fifo_level;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;
  int n_frames = 0;
  int n_b2b    = 0;

  ssp_tx_framer #(.FIFO_DEPTH(FIFO_DEPTH), .CLK_DIV(CLK_DIV)) dut (
    .ck_1356meg (ck_1356meg),
    .nrst       (nrst),
    .wr_data    (wr_data),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .enable     (enable),
    .test_mode  (test_mode),
    .ssp_clk    (ssp_clk),
    .ssp_frame  (ssp_frame),
    .ssp_din    (ssp_din),
    .fifo_level (fifo_level),
    .busy       (busy)
  );

  always #5 ck_1356meg = ~ck_1356meg;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge ck_1356meg);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] b);
    int n;
    n        = 0;
    wr_data  = b;
    wr_valid = 1'b1;
    while (!wr_ready && n < 400) begin
      step(1);
      n++;
    end
    check("push_accepted", 32'(wr_ready), 32'd1);
    step(1);
    wr_valid = 1'b0;
  endtask

  // Waits for a frame start, then samples one bit per bit period.
  task automatic capture(input logic [7:0] exp, input string name);
    int         n;
    logic [7:0] got;
    n   = 0;
    got = 8'h00;
    while (!ssp_frame && n < 500) begin
      step(1);
      n++;
    end
    check({name, "_frame_seen"}, 32'(ssp_frame), 32'd1);
    for (int k = 0; k < 8; k++) begin
      got[3'(7 - k)] = ssp_din;
      step(BIT_CYC);
    end
    check(name, 32'(got), 32'(exp));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    step(2);
    while (busy && n < 2000) begin
      step(1);
      n++;
    end
    check("wait_idle", 32'(busy), 32'd0);
    step(2);
  endtask

  // Model: expected byte stream and occupancy, derived from accepted writes,
  // the test pattern and the bit-period timing, checked every cycle.
  initial begin : compare
    logic [7:0]  fifo_mdl [256];
    logic [31:0] pat_word;
    logic [7:0]  cur;
    logic        win, ended, pend, en_prev, tm_prev;
    int          n_push, n_pop, pos, pat_idx, lvl;
    pat_word = 32'hDEADBEEF;
    cur = 8'h00; win = 1'b0; ended = 1'b0; pend = 1'b0; en_prev = 1'b0; tm_prev = 1'b0;
    n_push = 0; n_pop = 0; pos = 0; pat_idx = 0; lvl = 0;
    forever begin
      @(negedge ck_1356meg);
      if (!nrst) begin
        n_push = 0; n_pop = 0; pos = 0; pat_idx = 0;
        win = 1'b0; pend = 1'b0; en_prev = 1'b0; tm_prev = 1'b0;
      end else begin
        if (pend) n_push++;
        ended = 1'b0;
        if (win) begin
          pos++;
          if (pos == WIN) begin
            win   = 1'b0;
            ended = 1'b1;
          end
        end
        if (!win && ssp_frame === 1'b1) begin
          if (ended) n_b2b++;
          if (tm_prev) begin
            cur     = 8'(pat_word >> (8 * (3 - pat_idx)));
            pat_idx = (pat_idx + 1) % 4;
          end else begin
            check("frame_has_data", 32'(n_push > n_pop), 32'd1);
            cur = fifo_mdl[n_pop % 256];
            n_pop++;
          end
          win = 1'b1;
          pos = 0;
          n_frames++;
        end
        if (!tm_prev) pat_idx = 0;
        if (win) begin
          check("ssp_din",   32'(ssp_din),   32'(cur[3'(7 - pos / BIT_CYC)]));
          check("ssp_frame", 32'(ssp_frame), 32'(pos < BIT_CYC));
          check("ssp_clk",   32'(ssp_clk),   32'((pos / CLK_DIV) % 2));
          check("busy",      32'(busy),      32'd1);
        end else begin
          check("idle_din",  32'(ssp_din), 32'd0);
          check("idle_busy", 32'(busy),    32'd0);
          if (!en_prev) check("gated_ssp_clk", 32'(ssp_clk), 32'd0);
        end
        lvl = n_push - n_pop;
        check("fifo_level", 32'(fifo_level), 32'(lvl));
        check("wr_ready",   32'(wr_ready),   32'(lvl < FIFO_DEPTH));
        en_prev = enable;
        tm_prev = test_mode;
        pend    = wr_valid && wr_ready;
        if (pend) fifo_mdl[n_push % 256] = wr_data;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int n, f0, b0;

    // Reset state
    step(2);
    check("rst_ssp_clk",    32'(ssp_clk),    32'd0);
    check("rst_ssp_frame",  32'(ssp_frame),  32'd0);
    check("rst_ssp_din",    32'(ssp_din),    32'd0);
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_fifo_level", 32'(fifo_level), 32'd0);
    check("rst_wr_ready",   32'(wr_ready),   32'd1);
    nrst = 1'b1;
    step(2);

    // Single byte 0xA5 into an empty FIFO
    enable = 1'b1;
    step(3);
    push(8'hA5);
    capture(8'hA5, "byte_a5");
    step(WIN);
    check("a5_after_busy",  32'(busy),       32'd0);
    check("a5_after_din",   32'(ssp_din),    32'd0);
    check("a5_after_level", 32'(fifo_level), 32'd0);

    // Disabled with two bytes queued, then released
    enable = 1'b0;
    step(2);
    push(8'h12);
    push(8'h34);
    step(20);
    check("gated_level", 32'(fifo_level), 32'd2);
    check("gated_clk",   32'(ssp_clk),    32'd0);
    enable = 1'b1;
    n = 0;
    while (!ssp_frame && n < 100) begin
      step(1);
      n++;
    end
    check("enable_first_bit_latency", 32'(n), 32'd4);
    capture(8'h12, "byte_12");
    capture(8'h34, "byte_34");
    wait_idle();

    // Five bytes into a four-entry FIFO
    enable = 1'b0;
    step(2);
    push(8'hC1);
    push(8'h5E);
    push(8'h0F);
    push(8'hF0);
    check("full_wr_ready", 32'(wr_ready),   32'd0);
    check("full_level",    32'(fifo_level), 32'd4);
    f0 = n_frames;
    b0 = n_b2b;
    enable = 1'b1;
    push(8'h99);
    wait_idle();
    check("b2b_frames",     32'(n_frames - f0), 32'd5);
    check("b2b_contiguous", 32'(n_b2b - b0),    32'd4);

    // Enable dropped mid-byte: byte completes, next byte held
    f0 = n_frames;
    push(8'h3C);
    push(8'h81);
    n = 0;
    while (!ssp_frame && n < 100) begin
      step(1);
      n++;
    end
    step(3 * BIT_CYC);
    enable = 1'b0;
    step(WIN + 16);
    check("middrop_frames", 32'(n_frames - f0), 32'd1);
    check("middrop_busy",   32'(busy),          32'd0);
    check("middrop_clk",    32'(ssp_clk),       32'd0);
    check("middrop_level",  32'(fifo_level),    32'd1);

    // Asynchronous reset in the middle of a byte
    push(8'h55);
    check("prereset_level", 32'(fifo_level), 32'd2);
    enable = 1'b1;
    n = 0;
    while (!ssp_frame && n < 100) begin
      step(1);
      n++;
    end
    step(4 * BIT_CYC);
    #2 nrst = 1'b0;
    #1;
    check("async_rst_clk",   32'(ssp_clk),    32'd0);
    check("async_rst_frame", 32'(ssp_frame),  32'd0);
    check("async_rst_din",   32'(ssp_din),    32'd0);
    check("async_rst_busy",  32'(busy),       32'd0);
    check("async_rst_level", 32'(fifo_level), 32'd0);
    step(2);
    #2 nrst = 1'b1;
    check("post_rst_wr_ready", 32'(wr_ready), 32'd1);
    f0 = n_frames;
    step(2 * WIN);
    check("post_rst_frames", 32'(n_frames - f0), 32'd0);
    check("post_rst_level",  32'(fifo_level),    32'd0);
    check("post_rst_din",    32'(ssp_din),       32'd0);
    enable = 1'b0;
    step(4);

`ifdef SSP_TEST_PATTERN_EN
    // Test pattern: FIFO contents stay put while DE AD BE EF DE is sent
    push(8'h11);
    push(8'h22);
    test_mode = 1'b1;
    enable    = 1'b1;
    capture(8'hDE, "pat_0");
    capture(8'hAD, "pat_1");
    capture(8'hBE, "pat_2");
    capture(8'hEF, "pat_3");
    capture(8'hDE, "pat_4");
    check("pat_level", 32'(fifo_level), 32'd2);
    enable = 1'b0;
    wait_idle();
    test_mode = 1'b0;
    check("pat_level_end", 32'(fifo_level), 32'd2);
    step(4);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
